// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - per-key synchronizer, stable-time debounce, press/release pulses and press encoder
module key_debounce #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_out,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                key_valid,
    output logic [1:0]          key_code
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sync2;
    logic [CNT_W-1:0]    cnt      [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_next [NUM_KEYS];
    logic [NUM_KEYS-1:0] out_next;
    logic [NUM_KEYS-1:0] press_next;
    logic [NUM_KEYS-1:0] release_next;
    logic                valid_next;
    logic [1:0]          code_next;

    // Released state is all ones on the synchronizer so a held key after reset is re-debounced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    // Any sample matching the current level clears the window, so only an unbroken run commits.
    always_comb begin
        out_next     = key_out;
        press_next   = '0;
        release_next = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            cnt_next[i] = '0;
            if (sync2[i] != key_out[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    out_next[i]     = sync2[i];
                    press_next[i]   = ~sync2[i];
                    release_next[i] = sync2[i];
                end else begin
                    cnt_next[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Walk downward so the lowest pressed index wins; code holds when nothing is pressed.
    always_comb begin
        valid_next = |press_next;
        code_next  = key_code;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (press_next[i]) begin
                code_next = 2'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_out     <= '1;
            key_press   <= '0;
            key_release <= '0;
            key_valid   <= 1'b0;
            key_code    <= 2'd0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            key_out     <= out_next;
            key_press   <= press_next;
            key_release <= release_next;
            key_valid   <= valid_next;
            key_code    <= code_next;
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

endmodule
